// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and packing constants for the matmul scheduler
package matmul_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam int MAT_W  = 32;
    localparam int ELEM_W = 8;

    // Byte lanes of a packed 2x2 matrix {m00, m01, m10, m11}
    localparam int M00_LSB = 3 * ELEM_W;
    localparam int M01_LSB = 2 * ELEM_W;
    localparam int M10_LSB = 1 * ELEM_W;
    localparam int M11_LSB = 0;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, searches upward from ptr with wrap
module rr_arbiter
    import matmul_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int ID_W = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] id
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                id         = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/matmul2x2_sched.sv
// rtl/matmul2x2_sched.sv - round-robin job scheduler in front of one shared 2x2 matmul datapath
module matmul2x2_sched
    import matmul_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int ID_W    = 1,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*MAT_W-1:0] req_a,
    input  logic [NREQ*MAT_W-1:0] req_b,
    output logic                  mm_start,
    output logic [MAT_W-1:0]      mm_a,
    output logic [MAT_W-1:0]      mm_b,
    input  logic                  mm_done,
    input  logic [MAT_W-1:0]      mm_res,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [MAT_W-1:0]      rsp_res,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state_q;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  rr_ptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic             mm_start_q;
    logic [MAT_W-1:0] mm_a_q;
    logic [MAT_W-1:0] mm_b_q;
    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic [MAT_W-1:0] rsp_res_q;
    logic             rsp_err_q;

    logic [NREQ-1:0]  grant;
    logic [ID_W-1:0]  gnt_id;
    logic             xfer;

    // Grant is gated by rst so req_ready reads 0 while reset is held
    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .en    ((state_q == S_IDLE) && rst),
        .grant (grant),
        .id    (gnt_id)
    );

    assign xfer     = |grant;
    assign rr_ptr_d = (rsp_id_q == ID_W'(NREQ - 1)) ? '0 : rsp_id_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            mm_start_q  <= 1'b0;
            mm_a_q      <= '0;
            mm_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_res_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (xfer) begin
                        mm_a_q     <= req_a[MAT_W*int'(gnt_id) +: MAT_W];
                        mm_b_q     <= req_b[MAT_W*int'(gnt_id) +: MAT_W];
                        rsp_id_q   <= gnt_id;
                        mm_start_q <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mm_start_q <= 1'b0;
                    cnt_q      <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    // done takes priority over a timeout landing in the same cycle
                    if (mm_done) begin
                        rsp_res_q   <= mm_res;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        rsp_res_q   <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = grant;
    assign mm_start  = mm_start_q;
    assign mm_a      = mm_a_q;
    assign mm_b      = mm_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_matmul2x2_sched.sv
// tb/tb_matmul2x2_sched.sv - scoreboard bench for matmul2x2_sched with a behavioural datapath
module tb_matmul2x2_sched;

    localparam int NREQ    = 2;
    localparam int ID_W    = 1;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic        mm_start;
    logic [31:0] mm_a;
    logic [31:0] mm_b;
    logic        mm_done;
    logic [31:0] mm_res;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_res;
    logic        rsp_err;
    logic        busy;

    typedef struct {
        logic [0:0]  id;
        logic [31:0] res;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int          cyc = 0;
    int          start_cyc = -1;
    int          start_cnt = 0;
    int          done_k = 0;
    int          dcnt = 0;
    logic [31:0] prod = '0;
    logic        force_done = 1'b0;

    matmul2x2_sched #(
        .NREQ    (NREQ),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mm_start  (mm_start),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_done   (mm_done),
        .mm_res    (mm_res),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mm2(input logic [31:0] a, input logic [31:0] b);
        logic [7:0] a00, a01, a10, a11, b00, b01, b10, b11, c00, c01, c10, c11;
        {a00, a01, a10, a11} = a;
        {b00, b01, b10, b11} = b;
        c00 = a00 * b00 + a01 * b10;
        c01 = a00 * b01 + a01 * b11;
        c10 = a10 * b00 + a11 * b10;
        c11 = a10 * b01 + a11 * b11;
        return {c00, c01, c10, c11};
    endfunction

    // Datapath model: done pulses done_k cycles after mm_start (0 = never)
    assign mm_done = (dcnt == 1) | force_done;
    assign mm_res  = prod;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dcnt > 0) dcnt <= dcnt - 1;
        if (mm_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
            dcnt      <= done_k;
            prod      <= mm2(mm_a, mm_b);
        end
    end

    task automatic send(input int id, input logic [31:0] a, input logic [31:0] b, input int k,
                        output int t, output bit ok);
        exp_t e;
        @(negedge clk);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_valid[id] = 1'b1;
        done_k = k;
        ok = 1'b0;
        t = -1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (req_ready[id]) begin
                ok = 1'b1;
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            e.id  = 1'(id);
            e.err = (k == 0) || (k > TIMEOUT);
            e.res = e.err ? 32'h0 : mm2(a, b);
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int t, output bit ok);
        ok = 1'b0;
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                t = cyc;
                break;
            end
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset req_ready: got %b want 00", req_ready); end
        n_cmp++; if ({mm_start, mm_a, mm_b} !== 65'h0) begin n_bad++; $display("FAIL reset mm: got %b %h %h want 0", mm_start, mm_a, mm_b); end
        n_cmp++; if ({rsp_valid, rsp_id, rsp_res, rsp_err, busy} !== 36'h0) begin n_bad++; $display("FAIL reset rsp/busy: got %b %h %h %b %b want 0", rsp_valid, rsp_id, rsp_res, rsp_err, busy); end
        rst = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL reset rr_ptr grant: got %b want 01", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_single();
        int t, tr;
        bit ok, okr;
        exp_t e;
        send(0, 32'h01020304, 32'h05060708, 3, t, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single grant: got none want req0"); end
        wait_rsp(tr, okr);
        n_cmp++; if (!okr) begin n_bad++; $display("FAIL single rsp_valid: got timeout want response"); end
        n_cmp++; if (start_cyc !== t + 1) begin n_bad++; $display("FAIL single start cycle: got %0d want %0d", start_cyc, t + 1); end
        n_cmp++; if (tr !== t + 5) begin n_bad++; $display("FAIL single rsp cycle: got %0d want %0d", tr, t + 5); end
        e = sb.pop_front();
        n_cmp++; if (rsp_res !== 32'h13162B32 || e.res !== 32'h13162B32) begin n_bad++; $display("FAIL single res: got %h want 13162b32", rsp_res); end
        n_cmp++; if (rsp_id !== e.id || rsp_err !== e.err) begin n_bad++; $display("FAIL single id/err: got %0d/%b want %0d/%b", rsp_id, rsp_err, e.id, e.err); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single busy: got %b want 1", busy); end
        ack();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single idle busy: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int tr;
        bit okr;
        exp_t e;
        logic [31:0] a[2], b[2];
        logic [1:0] want;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            for (int r = 0; r < 2; r++) begin
                a[r] = $urandom;
                b[r] = $urandom;
            end
            req_a = {a[1], a[0]};
            req_b = {b[1], b[0]};
            done_k = j + 1;
            #1;
            want = (j % 2 == 0) ? 2'b01 : 2'b10;
            n_cmp++; if (req_ready !== want) begin n_bad++; $display("FAIL rr grant %0d: got %b want %b", j, req_ready, want); end
            e.id  = 1'(j % 2);
            e.err = 1'b0;
            e.res = mm2(a[j % 2], b[j % 2]);
            sb.push_back(e);
            wait_rsp(tr, okr);
            n_cmp++; if (!okr) begin n_bad++; $display("FAIL rr rsp %0d: got timeout want response", j); end
            e = sb.pop_front();
            n_cmp++; if (rsp_id !== e.id || rsp_res !== e.res || rsp_err !== e.err) begin
                n_bad++; $display("FAIL rr rsp %0d: got %0d/%h/%b want %0d/%h/%b", j, rsp_id, rsp_res, rsp_err, e.id, e.res, e.err);
            end
            ack();
        end
        req_valid = 2'b00;
    endtask

    task automatic test_timeout();
        int t, tr;
        bit ok, okr;
        exp_t e;
        send(1, 32'hDEADBEEF, 32'h11223344, 0, t, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL timeout grant: got none want req1"); end
        wait_rsp(tr, okr);
        n_cmp++; if (!okr) begin n_bad++; $display("FAIL timeout rsp_valid: got none want response"); end
        n_cmp++; if (tr - start_cyc !== TIMEOUT + 1) begin n_bad++; $display("FAIL timeout latency: got %0d want %0d", tr - start_cyc, TIMEOUT + 1); end
        e = sb.pop_front();
        n_cmp++; if (rsp_err !== 1'b1 || rsp_res !== 32'h0 || rsp_id !== e.id) begin
            n_bad++; $display("FAIL timeout rsp: got %0d/%h/%b want %0d/%h/%b", rsp_id, rsp_res, rsp_err, e.id, e.res, e.err);
        end
        ack();
    endtask

    task automatic test_backpressure();
        int t, tr, s0;
        bit ok, okr;
        exp_t e;
        send(0, 32'hFF80017F, 32'h02FE0310, 2, t, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp grant: got none want req0"); end
        wait_rsp(tr, okr);
        n_cmp++; if (!okr) begin n_bad++; $display("FAIL bp rsp_valid: got none want response"); end
        e = sb.pop_front();
        s0 = start_cnt;
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_res !== e.res || rsp_err !== e.err) begin
                n_bad++; $display("FAIL bp hold %0d: got %b/%0d/%h/%b want 1/%0d/%h/%b", i, rsp_valid, rsp_id, rsp_res, rsp_err, e.id, e.res, e.err);
            end
            n_cmp++; if (req_ready !== 2'b00 || start_cnt !== s0) begin
                n_bad++; $display("FAIL bp stall %0d: got ready %b starts %0d want 00 %0d", i, req_ready, start_cnt, s0);
            end
            @(negedge clk);
        end
        ack();
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL bp next grant: got %b want 10", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_done_at_timeout();
        int t, tr;
        bit ok, okr;
        exp_t e;
        send(0, 32'h0A0B0C0D, 32'h10203040, TIMEOUT, t, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL dat grant: got none want req0"); end
        wait_rsp(tr, okr);
        n_cmp++; if (!okr) begin n_bad++; $display("FAIL dat rsp_valid: got none want response"); end
        n_cmp++; if (tr - start_cyc !== TIMEOUT + 1) begin n_bad++; $display("FAIL dat latency: got %0d want %0d", tr - start_cyc, TIMEOUT + 1); end
        e = sb.pop_front();
        n_cmp++; if (rsp_err !== 1'b0 || rsp_res !== e.res || rsp_id !== e.id) begin
            n_bad++; $display("FAIL dat rsp: got %0d/%h/%b want %0d/%h/0", rsp_id, rsp_res, rsp_err, e.id, e.res);
        end
        ack();
    endtask

    task automatic test_reset_mid_wait();
        int t, s0;
        bit ok;
        send(1, 32'h12345678, 32'h9ABCDEF0, 0, t, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL midrst grant: got none want req1"); end
        sb.delete();
        repeat (4) @(negedge clk);
        s0 = start_cnt;
        rst = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        n_cmp++; if ({req_ready, mm_start, mm_a, mm_b} !== 67'h0) begin n_bad++; $display("FAIL midrst mm: got %b %b %h %h want 0", req_ready, mm_start, mm_a, mm_b); end
        n_cmp++; if ({rsp_valid, rsp_id, rsp_res, rsp_err, busy} !== 36'h0) begin n_bad++; $display("FAIL midrst rsp/busy: got %b %h %h %b %b want 0", rsp_valid, rsp_id, rsp_res, rsp_err, busy); end
        rst = 1'b1;
        req_valid = 2'b00;
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || start_cnt !== s0) begin
            n_bad++; $display("FAIL midrst late done: got valid %b busy %b starts %0d want 0 0 %0d", rsp_valid, busy, start_cnt, s0);
        end
        req_valid = 2'b11;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL midrst rr_ptr: got %b want 01", req_ready); end
        req_valid = 2'b00;
        n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard leftover: got %0d want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_backpressure();
        test_done_at_timeout();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
